// File: rtl/core_inst_pkg.sv
// Shared definitions for the core instruction sequencer: inst field map, idle word, FSM states.
package core_inst_pkg;

  localparam int INST_W = 35;
  localparam int A_W    = 11;

  localparam int I_LOAD     = 0;
  localparam int I_EXEC     = 1;
  localparam int I_L0_WR    = 2;
  localparam int I_L0_RD    = 3;
  localparam int I_IFIFO_RD = 4;
  localparam int I_IFIFO_WR = 5;
  localparam int I_OFIFO_RD = 6;
  localparam int I_AX_LSB   = 7;
  localparam int I_WEN_X    = 18;
  localparam int I_CEN_X    = 19;
  localparam int I_AP_LSB   = 20;
  localparam int I_WEN_P    = 31;
  localparam int I_CEN_P    = 32;
  localparam int I_ACC      = 33;
  localparam int I_MODE     = 34;

  // Both memories deselected, no strobes, addresses zero.
  localparam logic [INST_W-1:0] IDLE_WORD = (35'd1 << I_CEN_P) | (35'd1 << I_WEN_P) |
                                            (35'd1 << I_CEN_X) | (35'd1 << I_WEN_X);

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_GAPW, S_WXF, S_WLD, S_GAPL, S_AXF, S_GAPA,
    S_EXE, S_PRE, S_DRN, S_DONE, S_ACLR, S_ARD, S_ATL
  } seq_state_e;

  function automatic logic [3:0] isqrt(input logic [6:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 1; i <= 8; i++)
      if (i * i <= int'(v)) r = 4'(i);
    return r;
  endfunction

endpackage

// File: rtl/seq_addr_gen.sv
// Phase counter plus xmem (weight/activation) and pmem drain address generation.
module seq_addr_gen #(
  parameter int COL     = 8,
  parameter int W_BASE  = 1024,
  parameter int ADDR_BW = 11,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cnt_clr,
  input  logic [3:0]         kij,
  input  logic [6:0]         len,
  output logic [CNT_W-1:0]   cnt_q,
  output logic [ADDR_BW-1:0] a_x_w,
  output logic [ADDR_BW-1:0] a_x_a,
  output logic [ADDR_BW-1:0] a_p_drn
);

  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d   = cnt_clr ? '0 : cnt_q + 1'b1;
    // Addresses track the counter value the next cycle will present.
    a_x_w   = ADDR_BW'(W_BASE) + ADDR_BW'(kij) * ADDR_BW'(COL) + ADDR_BW'(cnt_d);
    a_x_a   = ADDR_BW'(cnt_d);
    a_p_drn = ADDR_BW'(kij) * ADDR_BW'(len) + ADDR_BW'(cnt_d);
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;

endmodule

// File: rtl/core_inst_sequencer.sv
// Generates the registered core inst word for each kij pass (WS/OS).
// Optional CORE_SEQ_ACC_EN adds a pmem accumulation phase after the last drain.
module core_inst_sequencer
  import core_inst_pkg::*;
#(
  parameter int ROW     = 8,
  parameter int COL     = 8,
  parameter int NIJ_MAX = 64,
  parameter int KIJ_MAX = 9,
  parameter int ADDR_BW = 11,
  parameter int W_BASE  = 1024,
  parameter int CLR_CYC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        cfg_mode,
  input  logic [6:0]  cfg_len_nij,
  input  logic [3:0]  cfg_num_kij,
  output logic [34:0] inst,
  output logic        core_clr,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij_idx
);

  localparam int CNT_W = 8;

  seq_state_e state_q, state_d;
  logic              mode_q, mode_d;
  logic [6:0]        len_q, len_d, len_c;
  logic [3:0]        nkij_q, nkij_d, nkij_c;
  logic [3:0]        kij_q, kij_d;
  logic [34:0]       inst_q, inst_d;
  logic              clr_q, clr_d, busy_q, busy_d, done_q, done_d;
  logic              cnt_clr;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_BW-1:0] a_x_w, a_x_a, a_p_drn;

  seq_addr_gen #(.COL(COL), .W_BASE(W_BASE), .ADDR_BW(ADDR_BW), .CNT_W(CNT_W)) u_addr (
    .clk(clk), .reset(reset), .cnt_clr(cnt_clr), .kij(kij_d), .len(len_d),
    .cnt_q(cnt_q), .a_x_w(a_x_w), .a_x_a(a_x_a), .a_p_drn(a_p_drn)
  );

  assign len_c  = (cfg_len_nij > 7'(NIJ_MAX)) ? 7'(NIJ_MAX) : cfg_len_nij;
  assign nkij_c = (cfg_num_kij > 4'(KIJ_MAX)) ? 4'(KIJ_MAX) : cfg_num_kij;

`ifdef CORE_SEQ_ACC_EN
  logic [3:0]         iw_q, iw_d, oy_q, oy_d, ox_q, ox_d;
  logic [CNT_W-1:0]   acc_k;
  logic [ADDR_BW-1:0] a_p_acc;

  // Read k of output (oy,ox) fetches kernel tap (k/3, k%3) of pass k.
  always_comb begin
    acc_k   = cnt_clr ? '0 : cnt_q + 1'b1;
    a_p_acc = ADDR_BW'(int'(acc_k) * int'(len_q) +
                       (int'(oy_d) + int'(acc_k) / 3) * int'(iw_q) +
                       int'(ox_d) + int'(acc_k) % 3);
  end
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    nkij_d  = nkij_q;
    kij_d   = kij_q;
`ifdef CORE_SEQ_ACC_EN
    iw_d = iw_q;
    oy_d = oy_q;
    ox_d = ox_q;
`endif
    unique case (state_q)
      S_IDLE:
        if (start && !abort) begin
          mode_d  = cfg_mode;
          len_d   = len_c;
          nkij_d  = nkij_c;
          kij_d   = '0;
          state_d = (len_c == '0 || nkij_c == '0) ? S_DONE : S_CLR;
`ifdef CORE_SEQ_ACC_EN
          iw_d = isqrt(len_c);
`endif
        end
      S_CLR:  if (cnt_q == CNT_W'(CLR_CYC - 1)) state_d = S_GAPW;
      S_GAPW: state_d = S_WXF;
      S_WXF:  if (cnt_q == CNT_W'(COL - 1)) state_d = (mode_q == MODE_OS) ? S_AXF : S_WLD;
      S_WLD:  if (cnt_q == CNT_W'(COL - 1)) state_d = S_GAPL;
      S_GAPL: state_d = S_AXF;
      S_AXF:  if (cnt_q == CNT_W'(len_q) - 1'b1) state_d = S_GAPA;
      S_GAPA: state_d = S_EXE;
      S_EXE:  if (cnt_q == CNT_W'(len_q) + CNT_W'(ROW + COL - 1)) state_d = S_PRE;
      S_PRE:  state_d = S_DRN;
      S_DRN:
        if (cnt_q == CNT_W'(len_q) - 1'b1) begin
          if (kij_q != nkij_q - 4'd1) begin
            kij_d   = kij_q + 4'd1;
            state_d = S_CLR;
          end else begin
`ifdef CORE_SEQ_ACC_EN
            oy_d    = '0;
            ox_d    = '0;
            state_d = (iw_q >= 4'd3) ? S_ACLR : S_DONE;
`else
            state_d = S_DONE;
`endif
          end
        end
`ifdef CORE_SEQ_ACC_EN
      S_ACLR: state_d = S_ARD;
      S_ARD:  if (cnt_q == CNT_W'(nkij_q) - 1'b1) state_d = S_ATL;
      S_ATL:
        if (ox_q == iw_q - 4'd3) begin
          ox_d = '0;
          if (oy_q == iw_q - 4'd3) state_d = S_DONE;
          else begin
            oy_d    = oy_q + 4'd1;
            state_d = S_ACLR;
          end
        end else begin
          ox_d    = ox_q + 4'd1;
          state_d = S_ACLR;
        end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
    cnt_clr = (state_d != state_q);
  end

  // Outputs are a function of the next state so they land in the same edge.
  always_comb begin
    busy_d = !(state_d inside {S_IDLE, S_DONE});
    done_d = (state_d == S_DONE);
    clr_d  = (state_d == S_CLR);
    inst_d = IDLE_WORD;
    if (busy_d) inst_d[I_MODE] = mode_d;
    unique case (state_d)
      S_WXF: begin
        inst_d[I_CEN_X] = 1'b0;
        inst_d[I_AX_LSB +: A_W] = a_x_w;
        if (mode_d == MODE_OS) inst_d[I_IFIFO_WR] = 1'b1;
        else                   inst_d[I_L0_WR]    = 1'b1;
      end
      S_WLD: begin
        inst_d[I_L0_RD] = 1'b1;
        inst_d[I_LOAD]  = 1'b1;
      end
      S_AXF: begin
        inst_d[I_CEN_X] = 1'b0;
        inst_d[I_L0_WR] = 1'b1;
        inst_d[I_AX_LSB +: A_W] = a_x_a;
      end
      S_EXE: begin
        inst_d[I_L0_RD] = 1'b1;
        inst_d[I_EXEC]  = 1'b1;
        if (mode_d == MODE_OS) inst_d[I_IFIFO_RD] = 1'b1;
      end
      S_PRE: inst_d[I_OFIFO_RD] = 1'b1;
      S_DRN: begin
        inst_d[I_OFIFO_RD] = 1'b1;
        inst_d[I_CEN_P]    = 1'b0;
        inst_d[I_WEN_P]    = 1'b0;
        inst_d[I_AP_LSB +: A_W] = a_p_drn;
      end
`ifdef CORE_SEQ_ACC_EN
      S_ACLR: clr_d = 1'b1;
      S_ARD: begin
        inst_d[I_CEN_P] = 1'b0;
        inst_d[I_AP_LSB +: A_W] = a_p_acc;
        inst_d[I_ACC]   = (acc_k != '0);
      end
      S_ATL: inst_d[I_ACC] = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      len_q   <= '0;
      nkij_q  <= '0;
      kij_q   <= '0;
      inst_q  <= IDLE_WORD;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CORE_SEQ_ACC_EN
      iw_q <= '0;
      oy_q <= '0;
      ox_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      nkij_q  <= nkij_d;
      kij_q   <= kij_d;
      inst_q  <= inst_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CORE_SEQ_ACC_EN
      iw_q <= iw_d;
      oy_q <= oy_d;
      ox_q <= ox_d;
`endif
    end
  end

  assign inst     = inst_q;
  assign core_clr = clr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign kij_idx  = kij_q;

endmodule
